// File: rtl/arb_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
package arb_pkg;

  localparam int unsigned ARB_AW = 32;
  localparam int unsigned ARB_DW = 32;

  // Arbiter FSM encoding; values are fixed so state can be traced in waves.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_e;

endpackage

// File: rtl/arb_perf_cnt.sv
// Free-running wait-cycle counter: counts enabled cycles, wraps at 2^W.
module arb_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and the MEM stage.
// Data accesses win over fetch. Each access runs IDLE -> BUSY -> RESP.
// Optional build macro ARB_PERF_CNT_EN adds perf_i_wait / perf_d_wait.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW = ARB_AW,
  parameter int unsigned DW = ARB_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_valid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic            d_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            stall_if,
  output logic            stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_i_wait,
  output logic [31:0]     perf_d_wait
`endif
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic            mem_req_d;
  logic            mem_we_d;
  logic [AW-1:0]   mem_addr_d;
  logic [DW-1:0]   mem_wdata_d;
  logic [DW/8-1:0] mem_wmask_d;
  logic            i_valid_d;
  logic            d_valid_d;
  logic [DW-1:0]   i_rdata_d;
  logic [DW-1:0]   d_rdata_d;

  // Next-state and next-register values; registers hold unless a state acts.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wmask_d = mem_wmask;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wmask_d = d_we ? d_wmask : '0;
        end else if (i_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d   = RESP_I;
          mem_req_d = 1'b0;
          i_rdata_d = mem_rdata;
          i_valid_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d   = RESP_D;
          mem_req_d = 1'b0;
          d_rdata_d = mem_rdata;
          d_valid_d = 1'b1;
        end
      end
      // Response cycle: requests are not sampled here, so a held request
      // is only relaunched after returning to IDLE.
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wmask <= mem_wmask_d;
      i_valid   <= i_valid_d;
      d_valid   <= d_valid_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

  // Pipeline stalls drop in the valid cycle so the pipeline advances that edge.
  assign stall_mem = d_req & ~d_valid;
  assign stall_if  = (i_req & ~i_valid) | stall_mem;

`ifdef ARB_PERF_CNT_EN
  // Cycles each requester spends waiting on the memory port.
  arb_perf_cnt #(.W(32)) u_perf_i (
    .clk   (clk),
    .rst   (rst),
    .en    (i_req & ~i_valid),
    .count (perf_i_wait)
  );

  arb_perf_cnt #(.W(32)) u_perf_d (
    .clk   (clk),
    .rst   (rst),
    .en    (d_req & ~d_valid),
    .count (perf_d_wait)
  );
`else
  // No wait-cycle counters in this build.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, compared against a transaction-timestamp reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst;
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_valid;
  logic [DW-1:0]   i_rdata;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wmask;
  logic            d_valid;
  logic [DW-1:0]   d_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;
  logic            stall_if;
  logic            stall_mem;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]     perf_i_wait;
  logic [31:0]     perf_d_wait;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_valid   (i_valid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_i_wait (perf_i_wait),
    .perf_d_wait (perf_d_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one outstanding transaction described by its accept
  // cycle and memory wait count; every expectation is timestamp arithmetic.
  int unsigned   cyc;
  bit            act;
  bit            fresh;
  bit            t_is_d;
  int unsigned   t_acc;
  int unsigned   t_w;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [3:0]    exp_wmask;
  logic [DW-1:0] exp_i_rdata;
  logic [DW-1:0] exp_d_rdata;
  logic [31:0]   exp_pi;
  logic [31:0]   exp_pd;

  // Stimulus knobs for directed scenarios.
  int            force_w;
  bit            use_rd;
  logic [DW-1:0] rd_val;
  int            n_stall_if;
  int            n_stall_mem;
  int            n_mem_req;
  int            n_valid;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_busy(input int unsigned c);
    return act && (c >= t_acc + 1) && (c <= t_acc + 1 + t_w);
  endfunction

  function automatic bit is_resp(input int unsigned c);
    return act && (c == t_acc + 2 + t_w);
  endfunction

  function automatic bit is_idle(input int unsigned c);
    return !act || (c >= t_acc + 3 + t_w);
  endfunction

  task automatic model_reset();
    act         = 1'b0;
    fresh       = 1'b1;
    exp_we      = 1'b0;
    exp_addr    = '0;
    exp_wdata   = '0;
    exp_wmask   = '0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    exp_pi      = '0;
    exp_pd      = '0;
  endtask

  // One clock cycle: requester inputs already set; drive memory, check, advance.
  task automatic step();
    bit ev_i;
    bit ev_d;
    bit rdy_cycle;
    rdy_cycle = act && (cyc == t_acc + 1 + t_w);
    if (!rst && in_busy(cyc) && rdy_cycle) mem_ready = 1'b1;
    else if (!in_busy(cyc))                mem_ready = ($urandom_range(0, 7) == 0);
    else                                   mem_ready = 1'b0;
    mem_rdata = use_rd ? rd_val : DW'($urandom);
    #1;
    ev_i = is_resp(cyc) && !t_is_d;
    ev_d = is_resp(cyc) && t_is_d;
    check_eq("mem_req", 64'(mem_req), 64'(in_busy(cyc)));
    if (in_busy(cyc) || fresh) begin
      check_eq("mem_we", 64'(mem_we), 64'(exp_we));
      check_eq("mem_addr", 64'(mem_addr), 64'(exp_addr));
      check_eq("mem_wmask", 64'(mem_wmask), 64'(exp_wmask));
      if (exp_we || fresh) check_eq("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    end
    check_eq("i_valid", 64'(i_valid), 64'(ev_i));
    check_eq("d_valid", 64'(d_valid), 64'(ev_d));
    check_eq("i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
    check_eq("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
    check_eq("stall_mem", 64'(stall_mem), 64'(d_req && !ev_d));
    check_eq("stall_if", 64'(stall_if), 64'((i_req && !ev_i) || (d_req && !ev_d)));
`ifdef ARB_PERF_CNT_EN
    check_eq("perf_i_wait", 64'(perf_i_wait), 64'(exp_pi));
    check_eq("perf_d_wait", 64'(perf_d_wait), 64'(exp_pd));
`endif
    n_stall_if  += int'(stall_if);
    n_stall_mem += int'(stall_mem);
    n_mem_req   += int'(mem_req);
    n_valid     += int'(i_valid) + int'(d_valid);

    if (rst) begin
      model_reset();
    end else begin
      if (i_req && !ev_i) exp_pi = exp_pi + 32'd1;
      if (d_req && !ev_d) exp_pd = exp_pd + 32'd1;
      if (rdy_cycle) begin
        if (t_is_d) exp_d_rdata = mem_rdata;
        else        exp_i_rdata = mem_rdata;
      end
      if (is_idle(cyc) && (d_req || i_req)) begin
        act    = 1'b1;
        fresh  = 1'b0;
        t_acc  = cyc;
        t_is_d = d_req;
        if (force_w >= 0)                     t_w = int'(force_w);
        else if ($urandom_range(0, 7) == 0)   t_w = $urandom_range(4, 12);
        else                                  t_w = $urandom_range(0, 3);
        if (d_req) begin
          exp_we    = d_we;
          exp_addr  = d_addr;
          exp_wdata = d_wdata;
          exp_wmask = d_we ? d_wmask : 4'h0;
        end else begin
          exp_we    = 1'b0;
          exp_addr  = i_addr;
          exp_wdata = '0;
          exp_wmask = 4'h0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_counts();
    n_stall_if  = 0;
    n_stall_mem = 0;
    n_mem_req   = 0;
    n_valid     = 0;
  endtask

  task automatic idle_inputs();
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_wmask = '0;
  endtask

  logic [31:0] pd0;
  logic [31:0] pi0;

  initial begin
    cyc       = 0;
    t_acc     = 0;
    t_w       = 0;
    t_is_d    = 1'b0;
    force_w   = -1;
    use_rd    = 1'b0;
    rd_val    = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    rst       = 1'b1;
    idle_inputs();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step();

    // Fetch, zero wait states.
    force_w = 0; use_rd = 1'b1; rd_val = 32'h0050_0093;
    clr_counts();
    i_req = 1'b1; i_addr = 32'h10;
    repeat (3) step();
    check_eq("t1_i_rdata", 64'(i_rdata), 64'h0050_0093);
    i_req = 1'b0;
    step();
    check_eq("t1_stall_if_cycles", 64'(n_stall_if), 64'd2);
    check_eq("t1_stall_mem_cycles", 64'(n_stall_mem), 64'd0);
    check_eq("t1_mem_req_cycles", 64'(n_mem_req), 64'd1);

    // Load with three wait states.
    force_w = 3; use_rd = 1'b0;
    clr_counts();
`ifdef ARB_PERF_CNT_EN
    pd0 = perf_d_wait; pi0 = perf_i_wait;
`else
    pd0 = '0; pi0 = '0;
`endif
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    repeat (6) step();
    d_req = 1'b0;
    step();
    check_eq("t2_stall_mem_cycles", 64'(n_stall_mem), 64'd5);
    check_eq("t2_mem_req_cycles", 64'(n_mem_req), 64'd4);
`ifdef ARB_PERF_CNT_EN
    check_eq("t2_perf_d_delta", 64'(perf_d_wait - pd0), 64'd5);
    check_eq("t2_perf_i_delta", 64'(perf_i_wait - pi0), 64'd0);
`endif

    // Simultaneous store and fetch: store first, then fetch after IDLE.
    force_w = 1;
    clr_counts();
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hBEEF; d_wmask = 4'b0011;
    repeat (4) step();
    d_req = 1'b0;
    repeat (4) step();
    i_req = 1'b0;
    step();
    check_eq("t3_stall_if_cycles", 64'(n_stall_if), 64'd7);
    check_eq("t3_valid_pulses", 64'(n_valid), 64'd2);

    // Fetch held across its valid pulse with a new address: one relaunch.
    force_w = 0;
    clr_counts();
    i_req = 1'b1; i_addr = 32'h40;
    repeat (2) step();
    i_addr = 32'h44;
    repeat (4) step();
    i_req = 1'b0;
    step();
    check_eq("t4_mem_req_cycles", 64'(n_mem_req), 64'd2);
    check_eq("t4_valid_pulses", 64'(n_valid), 64'd2);

    // Reset while a load waits on memory, then a normal fetch.
    force_w = 10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    repeat (3) step();
    clr_counts();
    d_req = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    force_w = 0;
    repeat (3) step();
    check_eq("t5_mem_req_after_rst", 64'(n_mem_req), 64'd1);
    check_eq("t5_no_valid", 64'(n_valid), 64'd0);
    i_req = 1'b1; i_addr = 32'h80;
    clr_counts();
    repeat (3) step();
    i_req = 1'b0;
    step();
    check_eq("t5_fetch_valid", 64'(n_valid), 64'd1);

    // Random traffic: held requests, flushes, random waits and resets.
    force_w = -1;
    for (int n = 0; n < 3000; n++) begin
      if (i_req && !i_valid) begin
        if ($urandom_range(0, 31) == 0) i_req = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        i_req  = 1'b1;
        i_addr = AW'($urandom);
      end else begin
        i_req = 1'b0;
      end
      if (d_req && !d_valid) begin
        if ($urandom_range(0, 31) == 0) d_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = AW'($urandom);
        d_wdata = DW'($urandom);
        d_wmask = 4'($urandom_range(0, 15));
      end else begin
        d_req = 1'b0;
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage and the MEM stage of the 5-stage RISC-V pipeline.
- Sequences each access through a small FSM and returns read data to the requester that issued it.
- Generates stall requests that are ORed with the load-use hazard stalls: stall_if goes into StallF/StallD, stall_mem freezes F/D/E/M.
- Data accesses have fixed priority over fetch.

Parameters:
AW, 32, address width
DW, 32, data width (byte mask width DW/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  fetch read request, level, held until i_valid
i_addr  in  AW  fetch address
i_valid  out  1  one-cycle pulse, i_rdata valid
i_rdata  out  DW  fetch read data, registered
d_req  in  1  data request, level, held until d_valid
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_wmask  in  DW/8  store byte enables
d_valid  out  1  one-cycle pulse, access complete (load data valid)
d_rdata  out  DW  load data, registered
mem_req  out  1  memory request, level, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  AW  latched address
mem_wdata  out  DW  latched write data
mem_wmask  out  DW/8  latched byte mask (all-zero on reads)
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, may assert in the first mem_req cycle
stall_if  out  1  freeze PC and IF/ID
stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB

Behaviour:
- Reset: clk and rst as above; rst is synchronous and active-high. On reset, state=IDLE and every output is 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, i_valid, d_valid, i_rdata, d_rdata.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - If d_req, latch d_* into the mem_* registers and go to BUSY_D.
  - Else if i_req, latch i_addr with mem_we=0 and mem_wmask=0, and go to BUSY_I.
  - Else stay in IDLE.
- BUSY_x:
  - mem_req=1 with address/data stable.
  - When mem_ready=1, capture mem_rdata into x_rdata, drop mem_req, and go to RESP_x.
  - Otherwise stay in BUSY_x; wait is unbounded.
- RESP_x: x_valid=1 for exactly this cycle, then go to IDLE. No new request is sampled in RESP, so a still-high request is not relaunched.
- Latency: request seen in IDLE at cycle t → mem_req at t+1 → mem_ready at t+1+W (W≥0) → valid at t+2+W.
  - Minimum is 3 cycles request-to-pipeline-advance, including one IDLE turnaround.
- Stores: d_rdata is updated with whatever mem_rdata shows; the pipeline ignores it.
- stall_mem = d_req & ~d_valid.
- stall_if = (i_req & ~i_valid) | stall_mem.
- Both stalls are combinational from registered state and request inputs, and deassert in the valid cycle so the pipeline advances that edge.
- Simultaneous i_req and d_req in IDLE: data wins. Fetch waits, and is stalled anyway by stall_mem.
- Request dropped while in BUSY (e.g. flush): the transaction completes to memory and the valid pulse is still issued; the requester ignores it.
- Reset mid-transaction: return to IDLE next edge and drop mem_req. The memory model tolerates the abandoned request.
- No address decode or alignment check is done here.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_i_wait[31:0] and perf_d_wait[31:0].
  - perf_i_wait counts cycles with i_req=1 and i_valid=0; perf_d_wait counts cycles with d_req=1 and d_valid=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package arb_pkg: state encoding constants (IDLE=3'd0, BUSY_I=1, BUSY_D=2, RESP_I=3, RESP_D=4) and the default AW/DW constants.
- Sub-module arb_perf_cnt (one counter, enable input, synchronous reset), instantiated twice only under ARB_PERF_CNT_EN.
- The FSM and datapath stay in one module.

Test Plan:
- Fetch only, zero-wait: i_req=1, addr 0x10, mem_ready in the first mem_req cycle, mem_rdata=0x00500093 → mem_req for 1 cycle, i_valid and i_rdata=0x00500093 two cycles after the request, stall_if high for 2 cycles, stall_mem never high.
- Load with 3 wait states: d_req=1, we=0, addr 0x100 → mem_addr=0x100, mem_wmask=0, mem_req for 4 cycles, d_valid pulse one cycle later, stall_mem high 5 cycles then low.
- Simultaneous requests: i_req and d_req both asserted in IDLE → store (we=1, wmask=4'b0011, wdata=0xBEEF) issued first. After d_valid and one IDLE cycle the fetch launches. stall_if stays high throughout.
- Held request after completion: i_req held high across i_valid with a new address → exactly one new transaction starts after RESP→IDLE, with no duplicate of the old address.
- Reset during BUSY_D with mem_ready low: rst=1 for one cycle → mem_req=0 next cycle, no valid pulses, state IDLE. A subsequent fetch completes normally.
- ARB_PERF_CNT_EN defined: run the 3-wait-state load → perf_d_wait=5, perf_i_wait unchanged.
